// File: rtl/mem_access.sv
// mem_access: MEM stage that turns loads/stores into 1-beat scalar or 4-beat matrix
// data-memory transactions, stalling upstream until the final ack.
`default_nettype none

module mem_access (
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  input  logic [31:0]  ex_alu_o,
  input  logic [31:0]  ex_rs2_data,
  input  logic [127:0] ex_matrix_o,
  input  logic [4:0]   ex_rd,
  input  logic         ex_mem2reg,
  input  logic         ex_mem_write,
  input  logic         ex_matrix_mem,
  input  logic [1:0]   ex_w_select,
  output logic         dm_req,
  output logic         dm_we,
  output logic [31:0]  dm_addr,
  output logic [31:0]  dm_wdata,
  input  logic         dm_ack,
  input  logic [31:0]  dm_rdata,
  output logic         stall,
  output logic [31:0]  me_mem_data,
  output logic [31:0]  me_alu_o,
  output logic [127:0] me_matrix_o,
  output logic [4:0]   me_rd,
  output logic         me_mem2reg,
  output logic [1:0]   me_w_select
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state_q;
  logic [1:0]     beat_q;
  logic           dm_req_q;
  logic           dm_we_q;
  logic [31:0]    dm_addr_q;
  logic [31:0]    dm_wdata_q;
  logic [31:0]    cap_alu_q;
  logic [127:0]   cap_mat_q;
  logic [4:0]     cap_rd_q;
  logic           cap_load_q;
  logic           cap_mm_q;
  logic [1:0]     cap_ws_q;
  logic [95:0]    asm_q;

  logic           w_mem_op;
  logic           w_final_beat;
  logic           w_fin_ack;
  logic [1:0]     beat_d;

  assign w_mem_op     = ex_valid & (ex_mem2reg | ex_mem_write);
  assign w_final_beat = cap_mm_q ? (beat_q == 2'd3) : (beat_q == 2'd0);
  assign w_fin_ack    = (state_q == BUSY) & dm_req_q & dm_ack & w_final_beat;
  assign beat_d       = beat_q + 2'd1;

  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;

  always_comb begin
    stall       = 1'b0;
    me_mem_data = 32'd0;
    me_alu_o    = 32'd0;
    me_matrix_o = 128'd0;
    me_rd       = 5'd0;
    me_mem2reg  = 1'b0;
    me_w_select = 2'd0;
    if (rst) begin
      if (state_q == IDLE) begin
        if (w_mem_op) begin
          stall = 1'b1;
        end else if (ex_valid) begin
          me_alu_o    = ex_alu_o;
          me_matrix_o = ex_matrix_o;
          me_rd       = ex_rd;
          me_mem2reg  = ex_mem2reg;
          me_w_select = ex_w_select;
        end
      end else if (w_fin_ack) begin
        me_alu_o    = cap_alu_q;
        me_rd       = cap_rd_q;
        me_mem2reg  = cap_load_q;
        me_w_select = cap_ws_q;
        me_mem_data = (cap_load_q & ~cap_mm_q) ? dm_rdata : 32'd0;
        me_matrix_o = (cap_load_q & cap_mm_q) ? {dm_rdata, asm_q} : cap_mat_q;
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'd0;
      dm_wdata_q <= 32'd0;
      cap_alu_q  <= 32'd0;
      cap_mat_q  <= 128'd0;
      cap_rd_q   <= 5'd0;
      cap_load_q <= 1'b0;
      cap_mm_q   <= 1'b0;
      cap_ws_q   <= 2'd0;
      asm_q      <= 96'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_mem_op) begin
            state_q    <= BUSY;
            beat_q     <= 2'd0;
            dm_req_q   <= 1'b1;
            // Load wins when both load and store flags are set.
            dm_we_q    <= ex_mem_write & ~ex_mem2reg;
            dm_addr_q  <= ex_matrix_mem ? {ex_alu_o[31:4], 4'b0000} : ex_alu_o;
            dm_wdata_q <= ex_matrix_mem ? ex_matrix_o[31:0] : ex_rs2_data;
            cap_alu_q  <= ex_alu_o;
            cap_mat_q  <= ex_matrix_o;
            cap_rd_q   <= ex_rd;
            cap_load_q <= ex_mem2reg;
            cap_mm_q   <= ex_matrix_mem;
            cap_ws_q   <= ex_w_select;
            asm_q      <= 96'd0;
          end
        end
        BUSY: begin
          if (dm_req_q && dm_ack) begin
            if (w_final_beat) begin
              state_q  <= IDLE;
              dm_req_q <= 1'b0;
            end else begin
              beat_q     <= beat_d;
              dm_addr_q  <= dm_addr_q + 32'd4;
              dm_wdata_q <= cap_mat_q[{beat_d, 5'd0} +: 32];
              case (beat_q)
                2'd0:    asm_q[31:0]  <= dm_rdata;
                2'd1:    asm_q[63:32] <= dm_rdata;
                default: asm_q[95:64] <= dm_rdata;
              endcase
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// tb_mem_access: random and directed stimulus against a transaction-level model of mem_access.
`default_nettype none

module tb_mem_access;

  logic         clk;
  logic         rst;
  logic         ex_valid;
  logic [31:0]  ex_alu_o;
  logic [31:0]  ex_rs2_data;
  logic [127:0] ex_matrix_o;
  logic [4:0]   ex_rd;
  logic         ex_mem2reg;
  logic         ex_mem_write;
  logic         ex_matrix_mem;
  logic [1:0]   ex_w_select;
  logic         dm_req;
  logic         dm_we;
  logic [31:0]  dm_addr;
  logic [31:0]  dm_wdata;
  logic         dm_ack;
  logic [31:0]  dm_rdata;
  logic         stall;
  logic [31:0]  me_mem_data;
  logic [31:0]  me_alu_o;
  logic [127:0] me_matrix_o;
  logic [4:0]   me_rd;
  logic         me_mem2reg;
  logic [1:0]   me_w_select;

  int total;
  int bad;

  mem_access dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_o(ex_alu_o), .ex_rs2_data(ex_rs2_data),
    .ex_matrix_o(ex_matrix_o), .ex_rd(ex_rd), .ex_mem2reg(ex_mem2reg),
    .ex_mem_write(ex_mem_write), .ex_matrix_mem(ex_matrix_mem), .ex_w_select(ex_w_select),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
    .me_mem_data(me_mem_data), .me_alu_o(me_alu_o), .me_matrix_o(me_matrix_o),
    .me_rd(me_rd), .me_mem2reg(me_mem2reg), .me_w_select(me_w_select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk(tag, {127'd0, |{me_rd, me_mem2reg, me_w_select, me_mem_data, me_alu_o, me_matrix_o}}, 128'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the op leaves MEM.
  task automatic do_op(input bit v, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [127:0] mat, input logic [4:0] rd, input bit m2r,
                       input bit mw, input bit mm, input logic [1:0] ws, input int dly,
                       input logic [127:0] rpat, input bit usepat);
    logic [31:0]  rdat [4];
    logic [31:0]  ea, ew;
    logic [127:0] exp_mat;
    logic [31:0]  exp_md;
    bit memop;
    int nb, d;
    memop = v && (m2r || mw);
    nb    = mm ? 4 : 1;
    ex_valid = v; ex_alu_o = alu; ex_rs2_data = rs2; ex_matrix_o = mat; ex_rd = rd;
    ex_mem2reg = m2r; ex_mem_write = mw; ex_matrix_mem = mm; ex_w_select = ws;
    dm_ack = 1'($urandom_range(0, 1));
    dm_rdata = $urandom;
    #1;
    chk("idle_req", {127'd0, dm_req}, 128'd0);
    if (!memop) begin
      chk("pt_stall", {127'd0, stall}, 128'd0);
      chk("pt_alu", {96'd0, me_alu_o}, v ? {96'd0, alu} : 128'd0);
      chk("pt_mat", me_matrix_o, v ? mat : 128'd0);
      chk("pt_ctl", {120'd0, me_rd, me_mem2reg, me_w_select}, v ? {120'd0, rd, 1'b0, ws} : 128'd0);
      chk("pt_mdata", {96'd0, me_mem_data}, 128'd0);
      @(posedge clk); #1;
      dm_ack = 1'b0;
      return;
    end
    chk("acc_stall", {127'd0, stall}, 128'd1);
    chk_bubble("acc_bubble");
    @(posedge clk); #1;
    dm_ack = 1'b0;
    for (int k = 0; k < nb; k++) begin
      ea = mm ? ({alu[31:4], 4'b0000} + 32'(4 * k)) : alu;
      ew = mm ? mat[32*k +: 32] : rs2;
      d  = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
      for (int w = 0; w < d; w++) begin
        #1;
        chk("wait_req", {127'd0, dm_req}, 128'd1);
        chk("wait_addr", {96'd0, dm_addr}, {96'd0, ea});
        chk("wait_wdata", {95'd0, dm_we, dm_wdata}, {95'd0, mw && !m2r, ew});
        chk("wait_stall", {127'd0, stall}, 128'd1);
        chk_bubble("wait_bubble");
        @(posedge clk); #1;
      end
      dm_ack = 1'b1;
      rdat[k] = usepat ? rpat[32*k +: 32] : $urandom;
      dm_rdata = rdat[k];
      #1;
      chk("ack_req", {127'd0, dm_req}, 128'd1);
      chk("ack_addr", {96'd0, dm_addr}, {96'd0, ea});
      chk("ack_we", {127'd0, dm_we}, {127'd0, mw && !m2r});
      chk("ack_wdata", {96'd0, dm_wdata}, {96'd0, ew});
      if (k == nb - 1) begin
        exp_md  = (m2r && !mm) ? rdat[0] : 32'd0;
        exp_mat = (m2r && mm) ? {rdat[3], rdat[2], rdat[1], rdat[0]} : mat;
        chk("fin_stall", {127'd0, stall}, 128'd0);
        chk("fin_alu", {96'd0, me_alu_o}, {96'd0, alu});
        chk("fin_ctl", {120'd0, me_rd, me_mem2reg, me_w_select}, {120'd0, rd, m2r, ws});
        chk("fin_mdata", {96'd0, me_mem_data}, {96'd0, exp_md});
        chk("fin_mat", me_matrix_o, exp_mat);
      end else begin
        chk("mid_stall", {127'd0, stall}, 128'd1);
        chk_bubble("mid_bubble");
      end
      @(posedge clk); #1;
      dm_ack = 1'b0;
    end
  endtask

  initial begin
    int kind;
    total = 0;
    bad   = 0;
    rst = 1'b0;
    ex_valid = 1'b1; ex_alu_o = 32'hABCD; ex_rs2_data = 32'h5; ex_matrix_o = 128'h77;
    ex_rd = 5'd3; ex_mem2reg = 1'b0; ex_mem_write = 1'b0; ex_matrix_mem = 1'b0;
    ex_w_select = 2'd2; dm_ack = 1'b0; dm_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall", {127'd0, stall}, 128'd0);
    chk_bubble("rst_bubble");
    chk("rst_dm", {62'd0, dm_req, dm_we, dm_addr, dm_wdata}, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    do_op(1, 32'h12345678, 0, 0, 5'd5, 0, 0, 0, 2'd1, 0, 0, 0);
    do_op(1, 32'h100, 0, 0, 5'd7, 1, 0, 0, 2'd0, 2, {96'd0, 32'hDEADBEEF}, 1);
    do_op(1, 32'h20C, 0, 0, 5'd9, 1, 0, 1, 2'd3, 0,
          128'h44444444_33333333_22222222_11111111, 1);
    do_op(1, 32'h400, 0, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 5'd2, 0, 1, 1, 2'd1, 1, 0, 0);
    do_op(1, 32'h104, 0, 0, 5'd4, 1, 0, 0, 2'd0, 0, 0, 0);
    do_op(1, 32'hCAFE0000, 0, 128'h1234, 5'd11, 0, 0, 0, 2'd2, 0, 0, 0);

    // Reset in the middle of a matrix load, during beat 2.
    ex_valid = 1; ex_alu_o = 32'h300; ex_rd = 5'd6; ex_mem2reg = 1; ex_mem_write = 0;
    ex_matrix_mem = 1; ex_w_select = 2'd1; dm_ack = 0;
    @(posedge clk); #1;
    dm_ack = 1; dm_rdata = 32'hBAD0;
    @(posedge clk); #1;
    dm_rdata = 32'hBAD1;
    @(posedge clk); #1;
    dm_ack = 0;
    #1;
    chk("mid_b2_addr", {96'd0, dm_addr}, {96'd0, 32'h308});
    rst = 1'b0;
    #1;
    chk("mid_rst_req", {127'd0, dm_req}, 128'd0);
    chk("mid_rst_stall", {127'd0, stall}, 128'd0);
    chk_bubble("mid_rst_bubble");
    ex_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    do_op(1, 32'h40, 0, 0, 5'd8, 1, 0, 0, 2'd0, 0, 0, 0);
    do_op(1, 32'h500, 0, 0, 5'd9, 1, 0, 1, 2'd2, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 3));
      do_op(($urandom_range(0, 9) != 0), $urandom, $urandom,
            {$urandom, $urandom, $urandom, $urandom}, 5'($urandom), kind[0], kind[1],
            1'($urandom_range(0, 1)), 2'($urandom), -1, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
